// File: rtl/button_conditioner.sv
// Four-lane active-low button synchroniser/debouncer with press pulses and a single hit-event slot.
// Optional release pulses are compiled in when BUTTON_COND_RELEASE_EN is defined.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] buttons_i,
  input  logic       arm_i,
  input  logic       hit_ready_i,
  output logic [3:0] held_o,
  output logic [3:0] hit_pulse_o,
  output logic [3:0] release_pulse_o,
  output logic       hit_valid_o,
  output logic [1:0] hit_lane_o,
  output logic       hit_multi_o,
  output logic [7:0] drop_count_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {S_EMPTY, S_FULL} slot_t;

  logic [3:0]            meta_q, sync_q, held_q, held_d, rise_d, hit_pulse_q;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
`ifdef BUTTON_COND_RELEASE_EN
  logic [3:0]            fall_d, release_q;
`endif

  slot_t      state_q, state_d;
  logic [1:0] lane_q, lane_d, first_lane;
  logic       multi_q, multi_d, capture;
  logic [7:0] drop_q, drop_d;

  // A lane flips only after CNT_LAST+1 consecutive disagreeing samples.
  always_comb begin
    held_d = held_q;
    rise_d = '0;
`ifdef BUTTON_COND_RELEASE_EN
    fall_d = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != held_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          held_d[i] = ~held_q[i];
          rise_d[i] = ~held_q[i];
`ifdef BUTTON_COND_RELEASE_EN
          fall_d[i] = held_q[i];
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q      <= '0;
      sync_q      <= '0;
      held_q      <= '0;
      cnt_q       <= '0;
      hit_pulse_q <= '0;
    end else begin
      meta_q      <= ~buttons_i;
      sync_q      <= meta_q;
      held_q      <= held_d;
      cnt_q       <= cnt_d;
      hit_pulse_q <= rise_d;
    end
  end

`ifdef BUTTON_COND_RELEASE_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) release_q <= '0;
    else       release_q <= fall_d;
  end
  assign release_pulse_o = release_q;
`else
  assign release_pulse_o = 4'b0000;
`endif

  always_comb begin
    first_lane = '0;
    for (int i = 3; i >= 0; i--) begin
      if (rise_d[i]) first_lane = 2'(i);
    end
  end

  assign capture = arm_i & (|rise_d);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    multi_d = multi_q;
    drop_d  = drop_q;
    case (state_q)
      S_EMPTY: begin
        if (capture) begin
          state_d = S_FULL;
          lane_d  = first_lane;
          multi_d = |(rise_d & (rise_d - 4'd1));
        end
      end
      S_FULL: begin
        // Accepting and capturing on one edge hands the slot straight to the new event.
        if (capture && hit_ready_i) begin
          lane_d  = first_lane;
          multi_d = |(rise_d & (rise_d - 4'd1));
        end else if (capture) begin
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end else if (hit_ready_i) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      lane_q  <= '0;
      multi_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      multi_q <= multi_d;
      drop_q  <= drop_d;
    end
  end

  assign held_o       = held_q;
  assign hit_pulse_o  = hit_pulse_q;
  assign hit_valid_o  = (state_q == S_FULL);
  assign hit_lane_o   = lane_q;
  assign hit_multi_o  = multi_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4 (press/release latency 6 edges).
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] buttons;
  logic       arm, hit_ready;
  logic [3:0] held, hit_pulse, release_pulse;
  logic       hit_valid, hit_multi;
  logic [1:0] hit_lane;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .buttons_i(buttons), .arm_i(arm), .hit_ready_i(hit_ready),
    .held_o(held), .hit_pulse_o(hit_pulse), .release_pulse_o(release_pulse),
    .hit_valid_o(hit_valid), .hit_lane_o(hit_lane), .hit_multi_o(hit_multi),
    .drop_count_o(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       arm;
    logic       rdy;
    logic [3:0] e_held;
    logic [3:0] e_hit;
    logic [3:0] e_rel;
    logic       e_valid;
    logic [1:0] e_lane;
    logic       e_multi;
    logic [7:0] e_drop;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rel_exp(input logic [3:0] e);
`ifdef BUTTON_COND_RELEASE_EN
    return e;
`else
    return 4'b0000 & e;
`endif
  endfunction

  initial begin
    rst = 1'b1; buttons = 4'hF; arm = 1'b1; hit_ready = 1'b0;
    tick(); tick();
    chk("rst_held", {4'b0, held}, 8'h00);
    chk("rst_hit", {4'b0, hit_pulse}, 8'h00);
    chk("rst_rel", {4'b0, release_pulse}, 8'h00);
    chk("rst_valid", {7'b0, hit_valid}, 8'h00);
    chk("rst_lane", {6'b0, hit_lane}, 8'h00);
    chk("rst_multi", {7'b0, hit_multi}, 8'h00);
    chk("rst_drop", drop_count, 8'h00);
    rst = 1'b0;

    // Lane 2 press, accept, then release.
    for (int i = 0; i < 5; i++)
      vecs[i] = '{4'b1011, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 8'd0};
    vecs[5]  = '{4'b1011, 1'b1, 1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0, 8'd0};
    vecs[6]  = '{4'b1011, 1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0, 8'd0};
    vecs[7]  = '{4'b1011, 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 8'd0};
    for (int i = 8; i < 13; i++)
      vecs[i] = '{4'b1111, 1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 8'd0};
    vecs[13] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b0, 8'd0};

    for (int i = 0; i < 14; i++) begin
      buttons = vecs[i].btn; arm = vecs[i].arm; hit_ready = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_held", i), {4'b0, held}, {4'b0, vecs[i].e_held});
      chk($sformatf("vec%0d_hit", i), {4'b0, hit_pulse}, {4'b0, vecs[i].e_hit});
      chk($sformatf("vec%0d_rel", i), {4'b0, release_pulse}, {4'b0, rel_exp(vecs[i].e_rel)});
      chk($sformatf("vec%0d_valid", i), {7'b0, hit_valid}, {7'b0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_lane", i), {6'b0, hit_lane}, {6'b0, vecs[i].e_lane});
        chk($sformatf("vec%0d_multi", i), {7'b0, hit_multi}, {7'b0, vecs[i].e_multi});
      end
      chk($sformatf("vec%0d_drop", i), drop_count, vecs[i].e_drop);
    end
    hit_ready = 1'b0;

    // Lane 0 bounces low for 3 cycles at a time: counter peaks one short of flipping.
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 5; c++) begin
        buttons = (c < 3) ? 4'b1110 : 4'b1111;
        tick();
        chk("bounce_held", {4'b0, held}, 8'h00);
        chk("bounce_hit", {4'b0, hit_pulse}, 8'h00);
        chk("bounce_valid", {7'b0, hit_valid}, 8'h00);
      end
    end
    repeat (4) tick();

    // Lanes 1 and 3 together.
    buttons = 4'b0101;
    repeat (5) tick();
    chk("multi_early_valid", {7'b0, hit_valid}, 8'h00);
    tick();
    chk("multi_hit", {4'b0, hit_pulse}, 8'h0A);
    chk("multi_valid", {7'b0, hit_valid}, 8'h01);
    chk("multi_lane", {6'b0, hit_lane}, 8'h01);
    chk("multi_multi", {7'b0, hit_multi}, 8'h01);

    // Three presses lost while the slot is full.
    buttons = 4'b0100; repeat (6) tick();
    chk("drop1", drop_count, 8'd1);
    chk("drop1_held", {4'b0, held}, 8'h0B);
    buttons = 4'b0000; repeat (6) tick();
    chk("drop2", drop_count, 8'd2);
    buttons = 4'b0001; repeat (6) tick();
    chk("rel0_held", {4'b0, held}, 8'h0E);
    chk("rel0_pulse", {4'b0, release_pulse}, {4'b0, rel_exp(4'b0001)});
    chk("rel0_drop", drop_count, 8'd2);
    buttons = 4'b0000; repeat (6) tick();
    chk("drop3", drop_count, 8'd3);
    chk("drop3_lane", {6'b0, hit_lane}, 8'h01);
    chk("drop3_multi", {7'b0, hit_multi}, 8'h01);
    chk("drop3_valid", {7'b0, hit_valid}, 8'h01);
    hit_ready = 1'b1; tick();
    chk("accept_valid", {7'b0, hit_valid}, 8'h00);
    hit_ready = 1'b0;

    buttons = 4'b1111; repeat (6) tick();
    chk("relall_held", {4'b0, held}, 8'h00);

    // Disarmed: levels and pulses update, nothing captured.
    arm = 1'b0;
    buttons = 4'b1101; repeat (6) tick();
    chk("disarm_held", {4'b0, held}, 8'h02);
    chk("disarm_hit", {4'b0, hit_pulse}, 8'h02);
    chk("disarm_valid", {7'b0, hit_valid}, 8'h00);
    chk("disarm_drop", drop_count, 8'd3);
    buttons = 4'b1111; repeat (6) tick();
    arm = 1'b1;

    // Accept and new capture on the same edge.
    buttons = 4'b0111; repeat (6) tick();
    chk("full_lane3", {6'b0, hit_lane}, 8'h03);
    buttons = 4'b0110; repeat (5) tick();
    chk("pre_swap_valid", {7'b0, hit_valid}, 8'h01);
    chk("pre_swap_lane", {6'b0, hit_lane}, 8'h03);
    hit_ready = 1'b1; tick();
    chk("swap_valid", {7'b0, hit_valid}, 8'h01);
    chk("swap_lane", {6'b0, hit_lane}, 8'h00);
    chk("swap_multi", {7'b0, hit_multi}, 8'h00);
    chk("swap_drop", drop_count, 8'd3);
    hit_ready = 1'b0; tick();
    chk("swap_hold_lane", {6'b0, hit_lane}, 8'h00);
    chk("swap_hold_valid", {7'b0, hit_valid}, 8'h01);

    // Reset mid-debounce with lane 0 held.
    buttons = 4'b1111; repeat (6) tick();
    buttons = 4'b1110; repeat (3) tick();
    rst = 1'b1; #1;
    chk("midrst_held", {4'b0, held}, 8'h00);
    chk("midrst_valid", {7'b0, hit_valid}, 8'h00);
    chk("midrst_drop", drop_count, 8'h00);
    chk("midrst_hit", {4'b0, hit_pulse}, 8'h00);
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("postrst_early_hit", {4'b0, hit_pulse}, 8'h00);
    tick();
    chk("postrst_hit", {4'b0, hit_pulse}, 8'h01);
    chk("postrst_held", {4'b0, held}, 8'h01);
    chk("postrst_valid", {7'b0, hit_valid}, 8'h01);
    chk("postrst_lane", {6'b0, hit_lane}, 8'h00);
    tick();
    chk("postrst_hit_width", {4'b0, hit_pulse}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-conditioning stage that sits directly upstream of the rhythm-game controller. It takes the four raw active-low lane push-buttons and synchronises and debounces each one, then turns presses into single-cycle pulses and a single valid/ready hit event. The controller consumes these as clean "lane N was struck" events instead of sampling raw key levels.

## Interface
- DEBOUNCE_CYCLES, 50000 — consecutive stable cycles required to accept a level change (1 ms at 50 MHz); legal range 2..65535.
- CNT_W, 16 — debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- buttons  in  4  raw lane keys, active-low (0 = pressed), asynchronous to clk.
- arm  in  1  1 = capture hit events; 0 = pulses/levels still update, no events captured.
- held  out  4  debounced level per lane, active-high (1 = pressed).
- hit_pulse  out  4  one-cycle pulse per lane on debounced press.
- release_pulse  out  4  one-cycle pulse per lane on debounced release (see Configuration).
- hit_valid  out  1  hit event pending.
- hit_lane  out  2  lane of pending event.
- hit_multi  out  1  more than one lane pressed in the capture cycle.
- hit_ready  in  1  consumer accepts event.
- drop_count  out  8  saturating count of presses lost while an event was pending.

## Operation
- Per lane: 2-flop synchroniser on ~buttons[i] -> sync[i]; stable register held[i]; counter cnt[i].
- Debounce: if sync[i] == held[i], cnt[i] <= 0. Else cnt[i] increments; on the edge where cnt[i] == DEBOUNCE_CYCLES-1 and sync[i] still differs, held[i] flips, cnt[i] <= 0.
- Any cycle with sync[i] == held[i] restarts the count (bounce shorter than DEBOUNCE_CYCLES is ignored).
- hit_pulse[i] registered on the same edge that flips held[i] 0->1; release_pulse[i] on 1->0.
- Event capture (arm = 1, any hit_pulse bit set this edge): slot loads hit_lane = lowest-index set bit, hit_multi = (more than one bit set), hit_valid <= 1.
- Slot states: EMPTY (hit_valid = 0) and FULL (hit_valid = 1). FULL -> EMPTY when hit_ready = 1 with no new capture.
- Simultaneous accept and capture (hit_valid & hit_ready & new press): slot reloads with new event, hit_valid stays 1, no drop.
- Press while FULL and hit_ready = 0: event discarded, slot unchanged, drop_count += 1, saturating at 255.
- arm = 0: no capture, no drop counting; a pending event remains until accepted.
- hit_lane/hit_multi stable while hit_valid = 1 and not accepted.

## Timing
- Reset values: held = 0, hit_pulse = 0, release_pulse = 0, hit_valid = 0, hit_lane = 0, hit_multi = 0, drop_count = 0; synchronisers = 0 (released); counters = 0.
- Reset mid-debounce discards progress; reset with key held produces a fresh press after 2 + DEBOUNCE_CYCLES cycles.
- Latency: buttons falling edge to held/hit_pulse = 2 (sync) + DEBOUNCE_CYCLES clock edges; hit_valid rises on the same edge as hit_pulse.
- hit_pulse width exactly one cycle; next press on the same lane requires a debounced release first.
- Handshake completes on any edge with hit_valid & hit_ready; hit_ready ignored when hit_valid = 0.

## Configuration
- BUTTON_COND_RELEASE_EN defined: release_pulse driven as above.
- Not defined: release_pulse tied to 4'b0000, release edge detect logic removed; debounce of releases (held 1->0) unchanged.

## Test plan
- DEBOUNCE_CYCLES = 4, buttons[2] driven low and held -> held[2] and hit_pulse[2] rise 6 edges later, hit_valid = 1, hit_lane = 2, hit_multi = 0.
- buttons[0] low for 3 cycles, then high, repeated 10 times -> held, hit_pulse, hit_valid never assert.
- buttons[1] and buttons[3] low on the same cycle, arm = 1 -> one event, hit_lane = 1, hit_multi = 1.
- Event pending, hit_ready = 0, three further debounced presses -> drop_count = 3, hit_lane unchanged; hit_ready = 1 -> hit_valid falls next edge.
- hit_ready = 1 on the edge a new press is debounced while FULL -> hit_valid stays 1, hit_lane = new lane, drop_count unchanged.
- rst asserted during lane 0 debounce with key held -> all outputs 0 immediately; after release of rst, hit_pulse[0] after 6 edges.
